// File: rtl/csr_reg_bank.sv
// csr_reg_bank: accelerator-side CSR register bank.
// Terminates the CSR req/rsp handshake, holds the configuration registers,
// issues a single-cycle start pulse and tracks busy/done status.
// Address map: 0..RegCount-3 = CFG (rw), RegCount-2 = PERF (ro),
// RegCount-1 = CTRL (write: bit0 start, bit1 clear done;
// read: bit0 busy, bit1 done).
// Optional feature: define CSR_REG_BANK_PERF_EN to build the PERF busy-cycle
// counter; without it PERF reads return 0.
module csr_reg_bank #(
   parameter int RegCount     = 8,
   parameter int RegDataWidth = 32,
   parameter int RegAddrWidth = $clog2(RegCount)
) (
   input  logic                                 clk_i,
   input  logic                                 rst_i,
   input  logic [RegAddrWidth-1:0]              csr_addr_i,
   input  logic [RegDataWidth-1:0]              csr_wr_data_i,
   input  logic                                 csr_wr_en_i,
   input  logic                                 csr_req_valid_i,
   output logic                                 csr_req_ready_o,
   output logic [RegDataWidth-1:0]              csr_rd_data_o,
   output logic                                 csr_rsp_valid_o,
   input  logic                                 csr_rsp_ready_i,
   output logic [(RegCount-2)*RegDataWidth-1:0] csr_reg_set_o,
   output logic                                 acc_start_o,
   input  logic                                 acc_busy_i,
   input  logic                                 acc_done_i
);

   localparam int NumCfg = RegCount - 2;
   localparam logic [RegAddrWidth-1:0] PerfAddr = RegAddrWidth'(RegCount - 2);
   localparam logic [RegAddrWidth-1:0] CtrlAddr = RegAddrWidth'(RegCount - 1);

   typedef enum logic {
      ST_IDLE,
      ST_RSP
   } state_t;

   state_t                    state_q;
   state_t                    state_d;
   logic [RegDataWidth-1:0]   cfg_q [NumCfg];
   logic [RegDataWidth-1:0]   rd_data_q;
   logic [RegDataWidth-1:0]   rd_mux;
   logic [RegDataWidth-1:0]   perf_val;
   logic                      done_q;
   logic                      start_q;
   logic                      is_cfg;
   logic                      is_perf;
   logic                      is_ctrl;
   logic                      stall;
   logic                      accept;
   logic                      rd_accept;
   logic                      wr_accept;
   logic                      ctrl_wr;

   // Address decode; anything above CTRL decodes to nothing (reads 0, writes dropped).
   assign is_cfg  = csr_addr_i < PerfAddr;
   assign is_perf = csr_addr_i == PerfAddr;
   assign is_ctrl = csr_addr_i == CtrlAddr;

   // Configuration must not change under a running accelerator, so CFG writes
   // wait for busy to drop; reads and CTRL writes always go through.
   assign stall           = csr_wr_en_i && is_cfg && acc_busy_i;
   assign csr_req_ready_o = (state_q == ST_IDLE) && !stall;
   assign accept          = csr_req_valid_i && csr_req_ready_o;
   assign rd_accept       = accept && !csr_wr_en_i;
   assign wr_accept       = accept && csr_wr_en_i;
   assign ctrl_wr         = wr_accept && is_ctrl;

   // FSM state register.
   always_ff @(posedge clk_i or posedge rst_i) begin
      // NOTE: non-blocking assignments in clocked blocks so every register
      // samples pre-edge values regardless of statement order.
      if (rst_i) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   // FSM next state and response-valid decode.
   always_comb begin
      // NOTE: defaults first so no path through the case leaves a signal
      // unassigned, which would infer a latch.
      state_d         = state_q;
      csr_rsp_valid_o = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (rd_accept) state_d = ST_RSP;
         end
         ST_RSP: begin
            csr_rsp_valid_o = 1'b1;
            if (csr_rsp_ready_i) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Configuration registers; written on the accept edge.
   always_ff @(posedge clk_i or posedge rst_i) begin
      // NOTE: this array is reset (unlike a RAM) because it drives the
      // accelerator directly and must come up in a known configuration.
      if (rst_i) begin
         for (int k = 0; k < NumCfg; k++) cfg_q[k] <= '0;
      end else begin
         for (int k = 0; k < NumCfg; k++) begin
            if (wr_accept && csr_addr_i == RegAddrWidth'(k)) cfg_q[k] <= csr_wr_data_i;
         end
      end
   end

   // Flatten the configuration registers onto the packed output bus.
   always_comb begin
      csr_reg_set_o = '0;
      for (int k = 0; k < NumCfg; k++) begin
         csr_reg_set_o[k*RegDataWidth +: RegDataWidth] = cfg_q[k];
      end
   end

   // Start pulse: one cycle after an accepted CTRL start write while idle.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) start_q <= 1'b0;
      else       start_q <= ctrl_wr && csr_wr_data_i[0] && !acc_busy_i;
   end

   assign acc_start_o = start_q;

   // Sticky done flag; a done pulse wins over a simultaneous clear.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)                                   done_q <= 1'b0;
      else if (acc_done_i)                         done_q <= 1'b1;
      else if ((ctrl_wr && csr_wr_data_i[1]) || start_q) done_q <= 1'b0;
   end

`ifdef CSR_REG_BANK_PERF_EN
   logic [RegDataWidth-1:0] perf_q;

   // Busy-cycle counter: restarts on the start pulse, saturates at all-ones.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)                       perf_q <= '0;
      else if (start_q)                perf_q <= '0;
      else if (acc_busy_i && !(&perf_q)) perf_q <= perf_q + 1'b1;
   end

   assign perf_val = perf_q;
`else
   assign perf_val = '0;
`endif

   // Read data selection for the addressed register.
   always_comb begin
      rd_mux = '0;
      for (int k = 0; k < NumCfg; k++) begin
         if (csr_addr_i == RegAddrWidth'(k)) rd_mux = cfg_q[k];
      end
      if (is_perf) rd_mux = perf_val;
      if (is_ctrl) rd_mux[1:0] = {done_q, acc_busy_i};
   end

   // Response data register; captured on read accept, held through RSP.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)          rd_data_q <= '0;
      else if (rd_accept) rd_data_q <= rd_mux;
   end

   assign csr_rd_data_o = rd_data_q;

endmodule

// File: tb/tb_csr_reg_bank.sv
// tb_csr_reg_bank: directed, table-driven bench for csr_reg_bank
// (RegCount = 8, RegDataWidth = 32), plus hand-written multi-cycle sequences.
module tb_csr_reg_bank;

   localparam int W = 32;
   localparam int N = 8;
   localparam int A = 3;

   logic           clk = 1'b0;
   logic           rst;
   logic [A-1:0]   addr;
   logic [W-1:0]   wr_data;
   logic           wr_en;
   logic           req_valid;
   logic           req_ready;
   logic [W-1:0]   rd_data;
   logic           rsp_valid;
   logic           rsp_ready;
   logic [(N-2)*W-1:0] reg_set;
   logic           acc_start;
   logic           acc_busy;
   logic           acc_done;

   int n_checks = 0;
   int n_errors = 0;

   typedef struct {
      logic         wr;
      logic [A-1:0] a;
      logic [W-1:0] d;
      logic [W-1:0] exp;
   } vec_t;

   vec_t vecs[10];

   csr_reg_bank #(.RegCount(N), .RegDataWidth(W)) dut (
      .clk_i           (clk),
      .rst_i           (rst),
      .csr_addr_i      (addr),
      .csr_wr_data_i   (wr_data),
      .csr_wr_en_i     (wr_en),
      .csr_req_valid_i (req_valid),
      .csr_req_ready_o (req_ready),
      .csr_rd_data_o   (rd_data),
      .csr_rsp_valid_o (rsp_valid),
      .csr_rsp_ready_i (rsp_ready),
      .csr_reg_set_o   (reg_set),
      .acc_start_o     (acc_start),
      .acc_busy_i      (acc_busy),
      .acc_done_i      (acc_done)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic do_write(input logic [A-1:0] a, input logic [W-1:0] d);
      @(negedge clk);
      req_valid = 1'b1; wr_en = 1'b1; addr = a; wr_data = d;
      @(negedge clk);
      req_valid = 1'b0; wr_en = 1'b0;
   endtask

   // Read with the response held off for 'hold' cycles (0 = accept at once).
   task automatic do_read(input string name, input logic [A-1:0] a, input logic [W-1:0] exp,
                          input int hold);
      @(negedge clk);
      req_valid = 1'b1; wr_en = 1'b0; addr = a; rsp_ready = (hold == 0);
      #1 check({name, " req_ready"}, req_ready, 1);
      @(negedge clk);
      req_valid = 1'b0;
      check({name, " rsp_valid"}, rsp_valid, 1);
      check({name, " rd_data"}, rd_data, exp);
      for (int i = 1; i < hold; i++) begin
         @(negedge clk);
         check({name, " held rsp_valid"}, rsp_valid, 1);
         check({name, " held rd_data"}, rd_data, exp);
         check({name, " held req_ready"}, req_ready, 0);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      check({name, " rsp_valid after"}, rsp_valid, 0);
      check({name, " req_ready after"}, req_ready, 1);
   endtask

   initial begin
      logic [W-1:0] perf_exp;
`ifdef CSR_REG_BANK_PERF_EN
      perf_exp = 32'd10;
`else
      perf_exp = 32'd0;
`endif
      vecs[0] = '{1'b1, 3'd0, 32'hDEADBEEF, 32'h0};
      vecs[1] = '{1'b0, 3'd0, 32'h0,        32'hDEADBEEF};
      vecs[2] = '{1'b1, 3'd1, 32'h12345678, 32'h0};
      vecs[3] = '{1'b1, 3'd5, 32'hA5A5A5A5, 32'h0};
      vecs[4] = '{1'b0, 3'd1, 32'h0,        32'h12345678};
      vecs[5] = '{1'b0, 3'd5, 32'h0,        32'hA5A5A5A5};
      vecs[6] = '{1'b1, 3'd6, 32'hFFFFFFFF, 32'h0};
      vecs[7] = '{1'b0, 3'd6, 32'h0,        32'h0};
      vecs[8] = '{1'b0, 3'd7, 32'h0,        32'h0};
      vecs[9] = '{1'b0, 3'd3, 32'h0,        32'h0};

      rst = 1'b1; addr = '0; wr_data = '0; wr_en = 1'b0; req_valid = 1'b0;
      rsp_ready = 1'b1; acc_busy = 1'b0; acc_done = 1'b0;

      // Reset state
      #2;
      check("reset req_ready", req_ready, 1);
      check("reset rsp_valid", rsp_valid, 0);
      check("reset rd_data", rd_data, 0);
      check("reset acc_start", acc_start, 0);
      check("reset reg_set", reg_set, 0);
      @(negedge clk);
      rst = 1'b0;

      // Table of basic writes and reads
      for (int i = 0; i < 10; i++) begin
         if (vecs[i].wr) do_write(vecs[i].a, vecs[i].d);
         else            do_read($sformatf("vec%0d", i), vecs[i].a, vecs[i].exp, 0);
      end
      check("reg_set cfg0", reg_set[31:0], 32'hDEADBEEF);
      check("reg_set cfg1", reg_set[63:32], 32'h12345678);
      check("reg_set cfg5", reg_set[191:160], 32'hA5A5A5A5);

      // Response back-pressure for 5 cycles
      do_read("hold rd1", 3'd1, 32'h12345678, 5);

      // CFG write stalled while busy
      @(negedge clk);
      acc_busy = 1'b1;
      req_valid = 1'b1; wr_en = 1'b1; addr = 3'd2; wr_data = 32'h5;
      #1 check("stall ready", req_ready, 0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("stall ready held", req_ready, 0);
         check("stall cfg2 unchanged", reg_set[95:64], 32'h0);
      end
      acc_busy = 1'b0;
      #1 check("stall release ready", req_ready, 1);
      @(negedge clk);
      req_valid = 1'b0; wr_en = 1'b0;
      check("stall cfg2 written", reg_set[95:64], 32'h5);

      // CTRL write while busy: not stalled, start dropped
      @(negedge clk);
      acc_busy = 1'b1;
      req_valid = 1'b1; wr_en = 1'b1; addr = 3'd7; wr_data = 32'h1;
      #1 check("busy ctrl ready", req_ready, 1);
      @(posedge clk); #1;
      check("busy start dropped", acc_start, 0);
      req_valid = 1'b0; wr_en = 1'b0;
      @(posedge clk); #1;
      check("busy start dropped 2", acc_start, 0);
      acc_busy = 1'b0;

      // Start pulse exactly one cycle
      @(negedge clk);
      req_valid = 1'b1; wr_en = 1'b1; addr = 3'd7; wr_data = 32'h1;
      #1 check("start before accept", acc_start, 0);
      @(posedge clk); #1;
      check("start pulse", acc_start, 1);
      req_valid = 1'b0; wr_en = 1'b0;
      @(posedge clk); #1;
      check("start pulse end", acc_start, 0);

      // Done flag set, read, cleared
      @(negedge clk); acc_done = 1'b1;
      @(negedge clk); acc_done = 1'b0;
      do_read("ctrl done", 3'd7, 32'h2, 0);
      do_write(3'd7, 32'h2);
      do_read("ctrl cleared", 3'd7, 32'h0, 0);

      // Done set and clear in the same cycle: set wins
      @(negedge clk);
      acc_done = 1'b1;
      req_valid = 1'b1; wr_en = 1'b1; addr = 3'd7; wr_data = 32'h2;
      @(negedge clk);
      acc_done = 1'b0; req_valid = 1'b0; wr_en = 1'b0;
      do_read("ctrl set wins", 3'd7, 32'h2, 0);

      // Start clears done; PERF counts 10 busy cycles
      do_write(3'd7, 32'h1);
      @(negedge clk);
      acc_busy = 1'b1;
      do_read("ctrl busy", 3'd7, 32'h1, 0);
      repeat (7) @(negedge clk);
      acc_busy = 1'b0;
      do_read("perf count", 3'd6, perf_exp, 0);
      do_read("ctrl after start", 3'd7, 32'h0, 0);

      // Reset while a response is pending
      @(negedge clk);
      req_valid = 1'b1; wr_en = 1'b0; addr = 3'd1; rsp_ready = 1'b0;
      @(negedge clk);
      req_valid = 1'b0;
      check("pre-reset rsp_valid", rsp_valid, 1);
      #2 rst = 1'b1;
      #1;
      check("async reset rsp_valid", rsp_valid, 0);
      check("async reset rd_data", rd_data, 0);
      check("async reset reg_set", reg_set, 0);
      @(negedge clk);
      rst = 1'b0;
      #1 check("post-reset req_ready", req_ready, 1);
      rsp_ready = 1'b1;
      @(negedge clk);
      check("post-reset no rsp", rsp_valid, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
